// File: rtl/rv_wb_pkg.sv
// Shared types for the register-file write-back path.
package rv_wb_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    typedef struct packed {
        reg_idx_t rd;
        xlen_t    data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Result, issue, hazard-check and register-file write signals of regfile_writeback.
interface regfile_writeback_if;
    import rv_wb_pkg::*;

    logic     alu_valid;
    reg_idx_t alu_rd;
    xlen_t    alu_data;
    logic     lsu_valid;
    logic     lsu_ready;
    reg_idx_t lsu_rd;
    xlen_t    lsu_data;
    logic     issue_valid;
    logic     issue_long;
    reg_idx_t issue_rd;
    reg_idx_t chk_rs1;
    reg_idx_t chk_rs2;
    reg_idx_t chk_rd;
    logic     stall;
    reg_idx_t wb_rd;
    xlen_t    wb_data;
    logic     wb_en;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_long, issue_rd,
        output chk_rs1, chk_rs2, chk_rd,
        input  lsu_ready, stall, wb_rd, wb_data, wb_en
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_long, issue_rd,
        input  chk_rs1, chk_rs2, chk_rd,
        output lsu_ready, stall, wb_rd, wb_data, wb_en
    );

endinterface

// File: rtl/wb_fifo.sv
// Long-latency result FIFO; DEPTH must be a power of two, pointers carry one wrap bit.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = rv_wb_pkg::wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    entry_t           mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates ALU and long-latency results onto one registered register-file write port
// and tracks pending long-latency destinations. Optional LSU bypass: WB_BYPASS_EN.
module regfile_writeback
    import rv_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    regfile_writeback_if.slave bus
);

    wb_entry_t             lsu_entry_c;
    wb_entry_t             head;
    logic                  full;
    logic                  empty;
    logic                  alu_sel_c;
    logic                  lsu_acc_c;
    logic                  bypass_c;
    logic                  fifo_push_c;
    logic                  fifo_pop_c;
    logic [NUM_REGS-1:0]   pending_q;
    logic [NUM_REGS-1:0]   set_mask_c;
    logic [NUM_REGS-1:0]   clr_mask_c;
    wb_entry_t             wb_q;
    wb_entry_t             wb_next_c;
    logic                  wb_en_q;
    logic                  wb_en_next_c;

    always_comb begin
        lsu_entry_c.rd   = bus.lsu_rd;
        lsu_entry_c.data = bus.lsu_data;
        alu_sel_c        = bus.alu_valid && (bus.alu_rd != '0);
        lsu_acc_c        = bus.lsu_valid && !full && (bus.lsu_rd != '0);
`ifdef WB_BYPASS_EN
        bypass_c         = lsu_acc_c && empty && !alu_sel_c;
`else
        bypass_c         = 1'b0;
`endif
        fifo_push_c      = lsu_acc_c && !bypass_c;
        fifo_pop_c       = !alu_sel_c && !empty;
    end

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_c),
        .push_data (lsu_entry_c),
        .pop       (fifo_pop_c),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // Write-port selection and scoreboard updates; ALU has priority over the FIFO.
    always_comb begin
        wb_en_next_c = 1'b0;
        wb_next_c    = wb_q;
        set_mask_c   = '0;
        clr_mask_c   = '0;
        if (alu_sel_c) begin
            wb_en_next_c     = 1'b1;
            wb_next_c.rd     = bus.alu_rd;
            wb_next_c.data   = bus.alu_data;
        end else if (fifo_pop_c) begin
            wb_en_next_c     = 1'b1;
            wb_next_c        = head;
            clr_mask_c[head.rd] = 1'b1;
        end else if (bypass_c) begin
            wb_en_next_c     = 1'b1;
            wb_next_c        = lsu_entry_c;
            clr_mask_c[bus.lsu_rd] = 1'b1;
        end
        if (bus.issue_valid && bus.issue_long && (bus.issue_rd != '0)) begin
            set_mask_c[bus.issue_rd] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            wb_q      <= '0;
            wb_en_q   <= 1'b0;
        end else begin
            pending_q <= ((pending_q & ~clr_mask_c) | set_mask_c) & ~NUM_REGS'(1);
            wb_q      <= wb_next_c;
            wb_en_q   <= wb_en_next_c;
        end
    end

    assign bus.lsu_ready = !full;
    assign bus.stall     = pending_q[bus.chk_rs1] | pending_q[bus.chk_rs2] | pending_q[bus.chk_rd];
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_rd     = wb_q.rd;
    assign bus.wb_data   = wb_q.data;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed plus random checks of regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
    import rv_wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    regfile_writeback_if bus ();

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wb_entry_t  q[$];
    bit [31:0]  pend;
    logic       exp_en;
    reg_idx_t   exp_rd;
    xlen_t      exp_data;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.issue_rd = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
    endtask

    task automatic model_reset();
        q.delete();
        pend     = '0;
        exp_en   = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
    endtask

    // Inputs are set just after a falling edge; advance one cycle and check.
    task automatic step();
        bit        ready, alu_sel, acc, byp;
        wb_entry_t e;
        #1;
        ready = (q.size() < DEPTH);
        chk("lsu_ready", 64'(bus.lsu_ready), 64'(ready));
        chk("stall", 64'(bus.stall), 64'(pend[bus.chk_rs1] | pend[bus.chk_rs2] | pend[bus.chk_rd]));
        alu_sel = bus.alu_valid && (bus.alu_rd != 0);
        acc     = bus.lsu_valid && ready && (bus.lsu_rd != 0);
        byp     = 1'b0;
`ifdef WB_BYPASS_EN
        byp     = acc && !alu_sel && (q.size() == 0);
`endif
        exp_en = 1'b1;
        if (alu_sel) begin
            exp_rd = bus.alu_rd; exp_data = bus.alu_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            exp_rd = e.rd; exp_data = e.data;
            pend[e.rd] = 1'b0;
        end else if (byp) begin
            exp_rd = bus.lsu_rd; exp_data = bus.lsu_data;
            pend[bus.lsu_rd] = 1'b0;
        end else begin
            exp_en = 1'b0;
        end
        if (acc && !byp) begin
            e.rd = bus.lsu_rd; e.data = bus.lsu_data;
            q.push_back(e);
        end
        if (bus.issue_valid && bus.issue_long && (bus.issue_rd != 0)) pend[bus.issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        chk("wb_en", 64'(bus.wb_en), 64'(exp_en));
        chk("wb_rd", 64'(bus.wb_rd), 64'(exp_rd));
        chk("wb_data", 64'(bus.wb_data), 64'(exp_data));
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wb_en", 64'(bus.wb_en), 64'(0));
        chk("rst_wb_rd", 64'(bus.wb_rd), 64'(0));
        chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
        chk("rst_ready", 64'(bus.lsu_ready), 64'(1));
        chk("rst_stall", 64'(bus.stall), 64'(0));
        rst = 1'b0;

        // ALU single-cycle write
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        step();
        chk("alu_wb_en", 64'(bus.wb_en), 64'(1));
        chk("alu_wb_data", 64'(bus.wb_data), 64'h1234);
        set_idle();
        step();

        // Long op to rd 7, stall, then LSU return
        bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd7;
        step();
        set_idle(); bus.chk_rs1 = 5'd7;
        step();
        chk("raw_stall", 64'(bus.stall), 64'(1));
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hDEADBEEF;
        step();
        set_idle(); bus.chk_rs1 = 5'd7;
        step();
        step();
        chk("rd7_cleared", 64'(bus.stall), 64'(0));

        // Fill FIFO under a held ALU stream, then drain
        for (int i = 0; i < 4; i++) begin
            set_idle();
            bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = reg_idx_t'(10 + i);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            set_idle();
            bus.alu_valid = 1'b1; bus.alu_rd = reg_idx_t'(20 + i); bus.alu_data = 32'hA000 + 32'(i);
            if (i < 4) begin
                bus.lsu_valid = 1'b1; bus.lsu_rd = reg_idx_t'(10 + i); bus.lsu_data = 32'hB000 + 32'(i);
            end
            step();
        end
        #1;
        chk("fifo_full", 64'(bus.lsu_ready), 64'(0));
        for (int i = 0; i < 6; i++) begin
            set_idle(); bus.chk_rs1 = 5'd10; bus.chk_rs2 = 5'd13;
            step();
        end

        // rd 0 results are dropped
        set_idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd = '0; bus.lsu_data = 32'h55;
        bus.alu_valid = 1'b1; bus.alu_rd = '0; bus.alu_data = 32'h66;
        step();
        set_idle();
        step();
        chk("rd0_no_wb", 64'(bus.wb_en), 64'(0));

        // Same-cycle reissue of rd 3 while its older entry pops
        set_idle(); bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd3;
        step();
        set_idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h3333;
        step();
        set_idle(); bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd3;
        step();
        set_idle(); bus.chk_rs1 = 5'd3;
        step();
        chk("set_wins", 64'(bus.stall), 64'(1));
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h3334;
        step();
        set_idle();
        step();

        // Reset mid-operation with queued entries and pending bits
        set_idle(); bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd14;
        step();
        bus.issue_rd = 5'd15;
        step();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd21; bus.alu_data = 32'hC000 + 32'(i);
            bus.lsu_valid = 1'b1; bus.lsu_rd = reg_idx_t'(14 + (i % 2)); bus.lsu_data = 32'hD000 + 32'(i);
            step();
        end
        set_idle(); bus.chk_rs1 = 5'd14; bus.chk_rs2 = 5'd15;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(bus.lsu_ready), 64'(1));
        chk("midrst_stall", 64'(bus.stall), 64'(0));
        chk("midrst_wb_en", 64'(bus.wb_en), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Random traffic honouring the issue contract
        for (int n = 0; n < 400; n++) begin
            set_idle();
            bus.alu_rd   = reg_idx_t'($urandom_range(0, 7));
            bus.alu_valid = ($urandom_range(0, 2) == 0) && !pend[bus.alu_rd];
            bus.alu_data = $urandom;
            bus.lsu_valid = $urandom_range(0, 1) == 1;
            bus.lsu_rd   = reg_idx_t'($urandom_range(0, 7));
            bus.lsu_data = $urandom;
            bus.issue_rd = reg_idx_t'($urandom_range(0, 7));
            bus.issue_long = $urandom_range(0, 1) == 1;
            bus.issue_valid = ($urandom_range(0, 3) == 0) && !pend[bus.issue_rd];
            bus.chk_rs1  = reg_idx_t'($urandom_range(0, 7));
            bus.chk_rs2  = reg_idx_t'($urandom_range(0, 7));
            bus.chk_rd   = reg_idx_t'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
